imem_loader: RTL and testbench

Boot-time writer for the processor's instruction-memory byte write port. Accepts 32-bit instruction words from a host over a valid/ready stream and serializes each into four byte writes (`write_address`, `write_data`, `We`). Holds `pc_enable` low while loading and releases it once the program is complete. Sits beside `processor` and drives its `We`, `write_address`, `write_data` and `pc_enable` inputs.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_byte_serializer.sv | 54 +++++
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Byte lanes are big-endian: lane 0 is the most significant byte of the word.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK    = 3'd3,
`endif
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LANE_FIRST     = 2'd0;
    localparam logic [1:0] LANE_LAST      = 2'(BYTES_PER_WORD - 1);

    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    be_byte = w[31:24];
            2'd1:    be_byte = w[23:16];
            2'd2:    be_byte = w[15:8];
            default: be_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/imem_byte_serializer.sv
// Turns one latched 32-bit word into four consecutive registered byte writes.
// `done` marks the cycle carrying the final byte so the FSM can move on at that edge.
module imem_byte_serializer
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [31:0] base,
    output logic [31:0] write_address,
    output logic [7:0]  write_data,
    output logic        we,
    output logic        done
);

    logic [31:0] word_q;
    logic [31:0] base_q;
    logic [1:0]  idx;
    logic [1:0]  idx_nx;

    assign idx_nx = idx + 2'd1;
    assign done   = we && (idx == LANE_LAST);

    // Async reset kills `we` at once so a reset mid-word stops writing immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we            <= 1'b0;
            idx           <= LANE_FIRST;
            word_q        <= '0;
            base_q        <= RST_ADDR;
            write_address <= RST_ADDR;
            write_data    <= '0;
        end else if (load) begin
            we            <= 1'b1;
            idx           <= LANE_FIRST;
            word_q        <= word;
            base_q        <= base;
            write_address <= base;
            write_data    <= be_byte(word, LANE_FIRST);
        end else if (we) begin
            if (done) begin
                we <= 1'b0;
            end else begin
                idx           <= idx_nx;
                write_address <= base_q + {30'd0, idx_nx};
                write_data    <= be_byte(word_q, idx_nx);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: streams host words into instruction memory as byte writes, then releases the PC.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum word before RUN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic [31:0]      write_address,
    output logic [7:0]       write_data,
    output logic             We,
    output logic             pc_enable,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t           state, state_nx;
    logic [CNT_W-1:0] wc_nx;
    logic             last_q;
    logic             hs_word;
    logic             ser_done;
    logic [31:0]      word_base;

    assign hs_word   = (state == ST_ACCEPT) && s_valid && s_ready;
    assign word_base = BASE_ADDR + (32'(word_count) << 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
    logic        sum_clr;

    assign sum_clr = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          sum_q <= '0;
        else if (sum_clr) sum_q <= '0;
        else if (hs_word) sum_q <= sum_q + s_data;
    end
`endif

    always_comb begin
        state_nx = state;
        wc_nx    = word_count;
        case (state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_nx = ST_ACCEPT;
                    wc_nx    = '0;
                end
            end
            ST_ACCEPT: begin
                if (hs_word) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                if (ser_done) begin
                    wc_nx = word_count + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (last_q)                 state_nx = ST_CHK;
`else
                    if (last_q)                 state_nx = ST_RUN;
`endif
                    else if (wc_nx == MAX_CNT)  state_nx = ST_ERR;
                    else                        state_nx = ST_ACCEPT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (s_valid && s_ready) state_nx = (s_data == sum_q) ? ST_RUN : ST_ERR;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    // `err` only leaves ERR via an accepted start, which makes it sticky by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            pc_enable  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            last_q     <= 1'b0;
        end else begin
            state      <= state_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
            s_ready    <= (state_nx == ST_ACCEPT) || (state_nx == ST_CHK);
            busy       <= (state_nx == ST_ACCEPT) || (state_nx == ST_WRITE) || (state_nx == ST_CHK);
`else
            s_ready    <= (state_nx == ST_ACCEPT);
            busy       <= (state_nx == ST_ACCEPT) || (state_nx == ST_WRITE);
`endif
            pc_enable  <= (state_nx == ST_RUN);
            err        <= (state_nx == ST_ERR);
            word_count <= wc_nx;
            if (hs_word) last_q <= s_last;
        end
    end

    imem_byte_serializer #(
        .RST_ADDR(BASE_ADDR)
    ) u_ser (
        .clk          (clk),
        .rst          (rst),
        .load         (hs_word),
        .word         (s_data),
        .base         (word_base),
        .write_address(write_address),
        .write_data   (write_data),
        .we           (We),
        .done         (ser_done)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load sessions with a write scoreboard, plus a reset-mid-word sequence.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int          CHKW = 1;
`else
    localparam int          CHKW = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [31:0] write_address;
    logic [7:0]  write_data;
    logic        We;
    logic        pc_enable;
    logic        busy;
    logic        err;
    logic [15:0] word_count;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .write_address(write_address),
        .write_data(write_data), .We(We), .pc_enable(pc_enable), .busy(busy),
        .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               n;
        logic [4:0][31:0] w;
        bit               last;
        logic [31:0]      off;
        int               hs;
        int               wc;
        bit               pc;
        bit               er;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  sb[$];
    wr_t  mon_e;
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_we_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Write monitor: every We cycle must match the oldest expected byte write.
    always @(negedge clk) begin
        if (We === 1'b1) begin
            last_we_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", write_address, write_data);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", write_address, mon_e.a);
                chk("wr_data", {24'd0, write_data}, {24'd0, mon_e.d});
            end
        end
    end

    task automatic push_word(input int k, input logic [31:0] w);
        for (int b = 0; b < 4; b++)
            sb.push_back('{a: BASE + 32'(4 * k + b), d: 8'(w >> (24 - 8 * b))});
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4,
                                input bit last, input logic [31:0] off, input int hs, input int wc,
                                input bit pc, input bit er);
        vec_t v;
        v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        v.last = last; v.off = off; v.hs = hs; v.wc = wc; v.pc = pc; v.er = er;
        return v;
    endfunction

    task automatic run_session(input vec_t v);
        int          hs, waits, n, ntot;
        bit          got;
        logic [31:0] sum, word;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_err_clr", {31'd0, err}, 32'd0);
        chk("start_s_ready", {31'd0, s_ready}, 32'd1);
        chk("start_pc_low", {31'd0, pc_enable}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        sum  = '0;
        hs   = 0;
        ntot = v.n + ((v.last && CHKW == 1) ? 1 : 0);
        s_valid = 1'b1;
        for (int k = 0; k < ntot; k++) begin
            if (k < v.n) begin
                word   = v.w[k];
                s_last = v.last && (k == v.n - 1);
                sum    = sum + word;
            end else begin
                word   = sum + v.off;
                s_last = 1'b0;
            end
            s_data = word;
            waits  = 0;
            got    = 1'b0;
            while (waits < 12) begin
                if (s_ready) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
                waits++;
            end
            if (!got) break;
            hs++;
            if (k < v.n) push_word(k, word);
            if (k > 0) chk("ready_gap", waits, 4);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("handshakes", hs, v.hs);
        n = 0;
        while (!(pc_enable || err) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pc_enable", {31'd0, pc_enable}, {31'd0, v.pc});
        chk("err", {31'd0, err}, {31'd0, v.er});
        chk("word_count", {16'd0, word_count}, v.wc);
        if (v.pc) chk("pc_latency", cyc - last_we_cyc, 1 + CHKW);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs.push_back(mk(2, 32'h2001_0005, 32'h0000_0000, 0, 0, 0, 1, 0, 2 + CHKW, 2, 1, 0));
        vecs.push_back(mk(3, 32'h1111_1111, 32'h2222_3333, 32'h4444_5555, 0, 0, 1, 0, 3 + CHKW, 3, 1, 0));
        vecs.push_back(mk(5, 32'hA0A0_0001, 32'hA1A1_0002, 32'hA2A2_0003, 32'hA3A3_0004, 32'hA4A4_0005,
                          0, 0, 4, 4, 0, 1));
        vecs.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 1 + CHKW, 1, 1, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back(mk(2, 32'h0000_0001, 32'h0000_0002, 0, 0, 0, 1, 0, 3, 2, 1, 0));
        vecs.push_back(mk(2, 32'h0000_0001, 32'h0000_0002, 0, 0, 0, 1, 1, 3, 2, 0, 1));
`endif

        repeat (2) @(negedge clk);
        chk("rst_We", {31'd0, We}, 32'd0);
        chk("rst_pc_enable", {31'd0, pc_enable}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_addr", write_address, BASE);
        chk("rst_data", {24'd0, write_data}, 32'd0);
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_s_ready", {31'd0, s_ready}, 32'd0);

        foreach (vecs[i]) run_session(vecs[i]);

        // Reset during the second byte of a word.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hCAFE_F00D;
        push_word(0, 32'hCAFE_F00D);
        @(negedge clk) s_valid = 1'b0;
        n = 0;
        while (!(We === 1'b1 && write_address === BASE + 32'd1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_byte1", {31'd0, n < 20}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_We", {31'd0, We}, 32'd0);
        chk("midrst_pc_enable", {31'd0, pc_enable}, 32'd0);
        chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_addr", write_address, BASE);
        chk("midrst_data", {24'd0, write_data}, 32'd0);
        chk("midrst_word_count", {16'd0, word_count}, 32'd0);
        sb.delete();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_ready", {31'd0, s_ready}, 32'd0);
        chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_no_we", {31'd0, We}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
